sm_stim_player: RTL and testbench

- Programmable pattern transmitter that drives the i1/i2 input pair of the team's 3-paragraph FSMs (sm_para_*), replacing hand-timed testbench stimulus with a synthesizable source.
- Stores up to DEPTH two-bit patterns and plays a selected number of them, each held for a programmable number of cycles, once or in a loop.
- Watches the FSM's err output and aborts playback when err is asserted.

---
 rtl/sm_stim_player.sv | 161 ++++++++++++++++
 tb/tb_sm_stim_player.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm_stim_player.sv
// sm_stim_player: programmable two-bit pattern transmitter feeding the i1/i2
// inputs of an sm_para_* FSM under test.
//
// A DEPTH-entry pattern memory is written at any time through wr_en/wr_addr/
// wr_data. A start with a legal len plays entries 0..len-1. Each entry is
// held for hold+1 cycles. Playback runs once, or loops when rpt is set. It
// ends early on stop (done pulse) or on err_in (sticky aborted, no done).
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   wr_en/addr/data   pattern memory write port ([1]=i1, [0]=i2)
//   start             begin playback when idle and 1 <= len <= DEPTH
//   len, hold, rpt    entry count, per-entry hold, loop enable (latched at start)
//   stop, err_in      early termination: normal stop / FSM error abort
//   i1, i2            registered stimulus outputs
//   busy, done        playing; one-cycle completion pulse
//   aborted           set by err_in abort, cleared by the next accepted start
//   idx               index of the entry currently driven
module sm_stim_player #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [CW-1:0] hold,
  input  logic          rpt,
  input  logic          stop,
  input  logic          err_in,
  output logic          i1,
  output logic          i2,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW-1:0] idx
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  state_t        state, state_n;
  logic [1:0]    mem [DEPTH];
  logic [AW:0]   len_q, len_n;
  logic [CW-1:0] hold_q, hold_n;
  logic          rpt_q, rpt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          i1_n, i2_n, busy_n, done_n, aborted_n;
  logic [AW-1:0] idx_n, idx_inc;
  logic          len_ok, last;

  // Pattern memory is intentionally not reset. Reads happen only in the
  // combinational load path below, so a write landing on the same edge as a
  // load of that address still yields the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign len_ok  = (len != '0) && (len <= DEPTH_L);
  assign last    = ({1'b0, idx} == (len_q - LEN_ONE));
  assign idx_inc = idx + IDX_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      i1      <= 1'b0;
      i2      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state   <= state_n;
      i1      <= i1_n;
      i2      <= i2_n;
      busy    <= busy_n;
      done    <= done_n;
      aborted <= aborted_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      len_q   <= len_n;
      hold_q  <= hold_n;
      rpt_q   <= rpt_n;
    end
  end

  always_comb begin
    state_n   = state;
    i1_n      = i1;
    i2_n      = i2;
    busy_n    = busy;
    done_n    = 1'b0;
    aborted_n = aborted;
    idx_n     = idx;
    cnt_n     = cnt;
    len_n     = len_q;
    hold_n    = hold_q;
    rpt_n     = rpt_q;

    unique case (state)
      IDLE: begin
        if (start && len_ok) begin
          len_n        = len;
          hold_n       = hold;
          rpt_n        = rpt;
          aborted_n    = 1'b0;
          {i1_n, i2_n} = mem[0];
          idx_n        = '0;
          cnt_n        = hold;
          busy_n       = 1'b1;
          state_n      = RUN;
        end
      end
      RUN: begin
        if (err_in) begin
          state_n      = IDLE;
          {i1_n, i2_n} = 2'b00;
          busy_n       = 1'b0;
          aborted_n    = 1'b1;
          idx_n        = '0;
        end else if (stop) begin
          state_n      = IDLE;
          {i1_n, i2_n} = 2'b00;
          busy_n       = 1'b0;
          done_n       = 1'b1;
          idx_n        = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!last) begin
          idx_n        = idx_inc;
          {i1_n, i2_n} = mem[idx_inc];
          cnt_n        = hold_q;
        end else if (rpt_q) begin
          // Wrap is modulo the latched len, not DEPTH.
          idx_n        = '0;
          {i1_n, i2_n} = mem[0];
          cnt_n        = hold_q;
        end else begin
          state_n      = IDLE;
          {i1_n, i2_n} = 2'b00;
          busy_n       = 1'b0;
          done_n       = 1'b1;
          idx_n        = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sm_stim_player.sv
// Directed bench for sm_stim_player: table-driven per-cycle vectors plus
// hand-written sequences for memory-write timing, len=DEPTH wrap and
// asynchronous reset.
module tb_sm_stim_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic       start = 1'b0;
  logic [4:0] len = '0;
  logic [3:0] hold = '0;
  logic       rpt = 1'b0;
  logic       stop = 1'b0;
  logic       err_in = 1'b0;
  logic       i1, i2, busy, done, aborted;
  logic [3:0] idx;

  int checks = 0;
  int failures = 0;

  sm_stim_player #(.DEPTH(16), .AW(4), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .hold(hold), .rpt(rpt),
    .stop(stop), .err_in(err_in),
    .i1(i1), .i2(i2), .busy(busy), .done(done), .aborted(aborted), .idx(idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       start;
    logic [4:0] len;
    logic [3:0] hold;
    logic       rpt;
    logic       stop;
    logic       err;
    logic [1:0] pat;
    logic       busy;
    logic       done;
    logic       ab;
    logic       chk_idx;
    logic [3:0] idx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic st, logic [4:0] ln, logic [3:0] hd,
                              logic rp, logic sp, logic er, logic [1:0] pt,
                              logic bz, logic dn, logic ab, logic ci, logic [3:0] ix);
    vec_t v;
    v.name = nm; v.start = st; v.len = ln; v.hold = hd; v.rpt = rp;
    v.stop = sp; v.err = er; v.pat = pt; v.busy = bz; v.done = dn;
    v.ab = ab; v.chk_idx = ci; v.idx = ix;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One rising edge; outputs are then sampled on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[n]) begin
      start = tbl[n].start; len = tbl[n].len; hold = tbl[n].hold;
      rpt = tbl[n].rpt; stop = tbl[n].stop; err_in = tbl[n].err;
      tick();
      start = 1'b0; stop = 1'b0; err_in = 1'b0;
      chk($sformatf("%s.%s[%0d].pat", tag, tbl[n].name, n), 32'({i1, i2}), 32'(tbl[n].pat));
      chk($sformatf("%s.%s[%0d].busy", tag, tbl[n].name, n), 32'(busy), 32'(tbl[n].busy));
      chk($sformatf("%s.%s[%0d].done", tag, tbl[n].name, n), 32'(done), 32'(tbl[n].done));
      chk($sformatf("%s.%s[%0d].aborted", tag, tbl[n].name, n), 32'(aborted), 32'(tbl[n].ab));
      if (tbl[n].chk_idx)
        chk($sformatf("%s.%s[%0d].idx", tag, tbl[n].name, n), 32'(idx), 32'(tbl[n].idx));
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    chk("reset.pat", 32'({i1, i2}), 32'(0));
    chk("reset.busy", 32'(busy), 32'(0));
    chk("reset.done", 32'(done), 32'(0));
    chk("reset.aborted", 32'(aborted), 32'(0));
    chk("reset.idx", 32'(idx), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single pass, len=4 hold=1: 8 busy cycles then a done pulse; bad len ignored.
    do_write(4'd0, 2'b10);
    do_write(4'd1, 2'b11);
    do_write(4'd2, 2'b01);
    do_write(4'd3, 2'b00);
    tbl.push_back(mk("play", 1, 5'd4, 4'd1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk("play", 0, 5'd4, 4'd1, 0, 0, 0, 2'b10, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk("play", 0, 5'd4, 4'd1, 0, 0, 0, 2'b11, 1, 0, 0, 1, 4'd1));
    tbl.push_back(mk("play", 0, 5'd4, 4'd1, 0, 0, 0, 2'b11, 1, 0, 0, 1, 4'd1));
    tbl.push_back(mk("play", 0, 5'd4, 4'd1, 0, 0, 0, 2'b01, 1, 0, 0, 1, 4'd2));
    tbl.push_back(mk("play", 0, 5'd4, 4'd1, 0, 0, 0, 2'b01, 1, 0, 0, 1, 4'd2));
    tbl.push_back(mk("play", 0, 5'd4, 4'd1, 0, 0, 0, 2'b00, 1, 0, 0, 1, 4'd3));
    tbl.push_back(mk("play", 0, 5'd4, 4'd1, 0, 0, 0, 2'b00, 1, 0, 0, 1, 4'd3));
    tbl.push_back(mk("play_done", 0, 5'd4, 4'd1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4'd0));
    tbl.push_back(mk("play_idle", 0, 5'd4, 4'd1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0));
    tbl.push_back(mk("len0", 1, 5'd0, 4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0));
    tbl.push_back(mk("len17", 1, 5'd17, 4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0));
    tbl.push_back(mk("bad_idle", 0, 5'd0, 4'd0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0));
    run_table("A");

    // Looping, stop, err abort, start-while-busy, err+stop priority.
    do_write(4'd0, 2'b11);
    do_write(4'd1, 2'b01);
    tbl.push_back(mk("loop", 1, 5'd2, 4'd0, 1, 0, 0, 2'b11, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk("loop", 0, 5'd2, 4'd0, 1, 0, 0, 2'b01, 1, 0, 0, 1, 4'd1));
    tbl.push_back(mk("loop", 0, 5'd2, 4'd0, 1, 0, 0, 2'b11, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk("loop", 0, 5'd2, 4'd0, 1, 0, 0, 2'b01, 1, 0, 0, 1, 4'd1));
    tbl.push_back(mk("loop", 0, 5'd2, 4'd0, 1, 0, 0, 2'b11, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk("stop", 0, 5'd2, 4'd0, 1, 1, 0, 2'b00, 0, 1, 0, 0, 4'd0));
    tbl.push_back(mk("stop_idle", 0, 5'd2, 4'd0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0));
    tbl.push_back(mk("errrun", 1, 5'd2, 4'd0, 1, 0, 0, 2'b11, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk("errrun", 0, 5'd2, 4'd0, 1, 0, 0, 2'b01, 1, 0, 0, 1, 4'd1));
    tbl.push_back(mk("errrun", 0, 5'd2, 4'd0, 1, 0, 0, 2'b11, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk("err", 0, 5'd2, 4'd0, 1, 0, 1, 2'b00, 0, 0, 1, 0, 4'd0));
    tbl.push_back(mk("err_idle", 0, 5'd2, 4'd0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 4'd0));
    tbl.push_back(mk("idle_errstop", 0, 5'd2, 4'd0, 1, 1, 1, 2'b00, 0, 0, 1, 0, 4'd0));
    tbl.push_back(mk("bad_keeps_ab", 1, 5'd0, 4'd0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 4'd0));
    tbl.push_back(mk("restart", 1, 5'd2, 4'd0, 1, 0, 0, 2'b11, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk("start_busy", 1, 5'd1, 4'd0, 0, 0, 0, 2'b01, 1, 0, 0, 1, 4'd1));
    tbl.push_back(mk("latched", 0, 5'd1, 4'd0, 0, 0, 0, 2'b11, 1, 0, 0, 1, 4'd0));
    tbl.push_back(mk("err_stop", 0, 5'd2, 4'd0, 1, 1, 1, 2'b00, 0, 0, 1, 0, 4'd0));
    tbl.push_back(mk("err_stop_idle", 0, 5'd2, 4'd0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 4'd0));
    run_table("B");

    // Write to a later entry while entry 0 plays; same-edge write/load of entry 2.
    do_write(4'd0, 2'b10);
    do_write(4'd1, 2'b11);
    do_write(4'd2, 2'b01);
    start = 1'b1; len = 5'd3; hold = 4'd2; rpt = 1'b0;
    tick();
    start = 1'b0;
    chk("wr.aborted_cleared", 32'(aborted), 32'(0));
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 2'b00;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    chk("wr.entry1_pat", 32'({i1, i2}), 32'(2'b00));
    chk("wr.entry1_idx", 32'(idx), 32'(1));
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 2'b11;
    tick();
    wr_en = 1'b0;
    chk("wr.same_edge_old", 32'({i1, i2}), 32'(2'b01));
    chk("wr.entry2_idx", 32'(idx), 32'(2));
    tick();
    tick();
    tick();
    chk("wr.done", 32'(done), 32'(1));
    chk("wr.busy_low", 32'(busy), 32'(0));
    start = 1'b1; len = 5'd3; hold = 4'd0;
    tick();
    start = 1'b0;
    chk("wr.replay0", 32'({i1, i2}), 32'(2'b10));
    tick();
    chk("wr.replay1", 32'({i1, i2}), 32'(2'b00));
    tick();
    chk("wr.replay2_new", 32'({i1, i2}), 32'(2'b11));
    tick();
    chk("wr.replay_done", 32'(done), 32'(1));

    // len=DEPTH: idx wraps 15 -> 0.
    for (int k = 0; k < 16; k++) do_write(4'(k), 2'(k));
    start = 1'b1; len = 5'd16; hold = 4'd0; rpt = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("wrap.idx%0d", k), 32'(idx), 32'(k % 16));
      chk($sformatf("wrap.pat%0d", k), 32'({i1, i2}), 32'((k % 16) % 4));
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wrap.stop_done", 32'(done), 32'(1));

    // Asynchronous reset mid-run.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("arst.pre_idx", 32'(idx), 32'(5));
    #2 rst = 1'b1;
    #1;
    chk("arst.pat", 32'({i1, i2}), 32'(0));
    chk("arst.busy", 32'(busy), 32'(0));
    chk("arst.idx", 32'(idx), 32'(0));
    chk("arst.done", 32'(done), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("arst.stays_idle", 32'(busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
